// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath width, ALU opcodes and the pipeline control bundle.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_t;

    // All-zero ctrl_t is a bubble: nothing writes, nothing touches memory.
    typedef struct packed {
        logic alusrc;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]      id_alu_ctrl;
    logic            id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_alu_ctrl;
    logic            ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
               id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_alu_ctrl, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
               id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_alu_ctrl, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check between the ID instruction and a load sitting in EX.
module load_use_detect
    import core_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       lu
);
    logic rs1_hit, rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign lu      = id_valid && ex_valid && ex_memread && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory-stall hold and bubble counter.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall_upstream,
    output logic [CNT_W-1:0] load_use_cnt
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    alu_op_t         alu_q;
    ctrl_t           ctrl_q, id_ctrl;
    logic [CNT_W-1:0] cnt_q;
    logic            lu;

    assign id_ctrl = '{alusrc:   bus.id_alusrc,   regwrite: bus.id_regwrite,
                       memread:  bus.id_memread,  memwrite: bus.id_memwrite,
                       memtoreg: bus.id_memtoreg, branch:   bus.id_branch};

    load_use_detect u_lu (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_valid    (valid_q),
        .ex_memread  (ctrl_q.memread),
        .ex_rd       (rd_q),
        .lu          (lu)
    );

    assign stall_upstream = mem_stall || (lu && !flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!mem_stall && lu)) begin
            // Reset, flush and load-use all leave a fully zeroed bubble behind.
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_q      <= ALU_ADD;
            ctrl_q     <= '0;
        end else if (!mem_stall) begin
            valid_q    <= bus.id_valid;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            alu_q      <= alu_op_t'(bus.id_alu_ctrl);
            ctrl_q     <= bus.id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!flush && !mem_stall && lu && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign load_use_cnt    = cnt_q;
    assign bus.ex_valid    = valid_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_alu_ctrl = alu_q;
    assign bus.ex_alusrc   = ctrl_q.alusrc;
    assign bus.ex_regwrite = ctrl_q.regwrite;
    assign bus.ex_memread  = ctrl_q.memread;
    assign bus.ex_memwrite = ctrl_q.memwrite;
    assign bus.ex_memtoreg = ctrl_q.memtoreg;
    assign bus.ex_branch   = ctrl_q.branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic against a reference model.
module tb_id_ex_stage;
    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    // Control bit order in the 6-bit vectors below: alusrc,regwrite,memread,memwrite,memtoreg,branch
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_ALU  = 6'b010000;
    localparam logic [5:0] C_LOAD = 6'b111010;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic mem_stall = 1'b0;
    logic stall_upstream;
    logic [CNT_W-1:0] load_use_cnt;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .flush          (flush),
        .mem_stall      (mem_stall),
        .stall_upstream (stall_upstream),
        .load_use_cnt   (load_use_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what the EX stage is holding, as a plain record.
    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [5:0]  ctrl;
    } ex_rec_t;

    ex_rec_t m;
    int      m_cnt;

    function automatic ex_rec_t empty_rec();
        ex_rec_t r;
        r.valid = 1'b0; r.pc = '0; r.d1 = '0; r.d2 = '0; r.imm = '0;
        r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.alu = '0; r.ctrl = '0;
        return r;
    endfunction

    // A hazard exists when EX holds a real load to a nonzero register that ID actually reads.
    function automatic bit model_hazard();
        bit ex_is_load, reads;
        ex_is_load = m.valid && m.ctrl[3] && (m.rd != 0);
        reads = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
        return bus.id_valid && ex_is_load && reads;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, bus.ex_valid, m.valid);
        chk({tag, ".pc"},    bus.ex_pc, m.pc);
        chk({tag, ".d1"},    bus.ex_rs1_data, m.d1);
        chk({tag, ".d2"},    bus.ex_rs2_data, m.d2);
        chk({tag, ".imm"},   bus.ex_imm, m.imm);
        chk({tag, ".idx"},   {bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {m.rs1, m.rs2, m.rd});
        chk({tag, ".alu"},   bus.ex_alu_ctrl, m.alu);
        chk({tag, ".ctrl"},  {bus.ex_alusrc, bus.ex_regwrite, bus.ex_memread,
                              bus.ex_memwrite, bus.ex_memtoreg, bus.ex_branch}, m.ctrl);
        chk({tag, ".cnt"},   load_use_cnt, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                         input logic u1, u2, input logic [5:0] c, input logic fl, ms);
        bus.id_valid = v;     bus.id_pc = pc;
        bus.id_rs1 = rs1;     bus.id_rs2 = rs2;     bus.id_rd = rd;
        bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
        bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
        bus.id_alu_ctrl = 4'($urandom_range(0, 15));
        {bus.id_alusrc, bus.id_regwrite, bus.id_memread,
         bus.id_memwrite, bus.id_memtoreg, bus.id_branch} = c;
        flush = fl; mem_stall = ms;
    endtask

    // One clock: check the same-cycle stall, advance model at the edge, check registers after it.
    task automatic cycle(input string tag);
        bit hz;
        #1;
        hz = model_hazard();
        chk({tag, ".stall"}, stall_upstream, mem_stall || (hz && !flush));
        @(posedge clk);
        if (flush) m = empty_rec();
        else if (mem_stall) begin end
        else if (hz) begin
            m = empty_rec();
            if (m_cnt < SAT) m_cnt++;
        end else begin
            m.valid = bus.id_valid; m.pc = bus.id_pc;
            m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data; m.imm = bus.id_imm;
            m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
            m.alu = bus.id_alu_ctrl;
            m.ctrl = bus.id_valid ? {bus.id_alusrc, bus.id_regwrite, bus.id_memread,
                                     bus.id_memwrite, bus.id_memtoreg, bus.id_branch} : 6'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        m = empty_rec();
        m_cnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset.stall", stall_upstream, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain flow
        drive(1, 32'h100, 1, 2, 5, 1, 1, C_ALU, 0, 0);
        cycle("flow");
        chk("flow.rd", bus.ex_rd, 5'd5);
        chk("flow.pc", bus.ex_pc, 32'h100);

        // Load-use: lw x6 then add using x6
        drive(1, 32'h104, 1, 0, 6, 1, 0, C_LOAD, 0, 0);
        cycle("lw6");
        drive(1, 32'h108, 6, 3, 7, 1, 1, C_ALU, 0, 0);
        cycle("lu_bubble");
        chk("lu.valid0", bus.ex_valid, 1'b0);
        chk("lu.cnt1", load_use_cnt, 2'd1);
        cycle("lu_release");
        chk("lu.add_pc", bus.ex_pc, 32'h108);

        // False hazards
        drive(1, 32'h10c, 1, 0, 0, 1, 0, C_LOAD, 0, 0);  cycle("lw_x0");
        drive(1, 32'h110, 0, 0, 9, 1, 1, C_ALU, 0, 0);   cycle("use_x0");
        drive(1, 32'h114, 1, 0, 7, 1, 0, C_LOAD, 0, 0);  cycle("lw7");
        drive(1, 32'h118, 1, 7, 9, 1, 0, C_ALU, 0, 0);   cycle("rs2_unused");
        drive(1, 32'h11c, 1, 0, 8, 1, 0, C_ALU, 0, 0);   cycle("alu8");
        drive(1, 32'h120, 8, 8, 9, 1, 1, C_ALU, 0, 0);   cycle("no_memread");

        // mem_stall held 3 cycles with changing ID inputs
        drive(1, 32'h124, 1, 2, 11, 1, 1, C_LOAD, 0, 0); cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, 11, 11, 5'($urandom), 1, 1, 6'($urandom), 0, 1);
            cycle("mem_stall");
        end

        // flush + lu + mem_stall together, EX still holds lw x11
        drive(1, 32'h128, 11, 0, 12, 1, 0, C_ALU, 1, 1);
        cycle("all_three");
        chk("all_three.valid", bus.ex_valid, 1'b0);

        // Saturation: five load-use events
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 8 * i, 1, 0, 10, 1, 0, C_LOAD, 0, 0); cycle("sat_lw");
            drive(1, 32'h204 + 8 * i, 0, 10, 13, 0, 1, C_ALU, 0, 0); cycle("sat_bubble");
            cycle("sat_use");
        end
        chk("sat.cnt", load_use_cnt, 2'd3);

        // Random traffic, small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) != 0, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 6'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
            cycle("rand");
        end

        // Asynchronous reset mid-cycle with EX holding a load
        drive(1, 32'h300, 1, 0, 14, 1, 0, C_LOAD, 0, 0); cycle("pre_rst");
        drive(1, 32'h304, 14, 0, 15, 1, 0, C_ALU, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        m = empty_rec();
        m_cnt = 0;
        check_outputs("mid_rst");
        chk("mid_rst.stall", stall_upstream, 1'b1);
        mem_stall = 1'b0;
        #1;
        chk("mid_rst.stall_lu", stall_upstream, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
